fifo_ctrl: RTL

- Pointer, flag and handshake controller for the 8-entry x 32-bit register-file FIFO.
- Drives the write address and write strobe for the register file.
- Drives the read address into the 8-to-1 read mux stage and registers the mux's output data as the FIFO output.
- One clock, with state held in head/tail pointers, an occupancy counter and a six-state FSM.

---
 rtl/fifo_ctrl.sv | 98 +++++++++
 1 files changed

// File: rtl/fifo_ctrl.sv
// Pointer, flag and handshake controller for an 8-entry x 32-bit register-file FIFO.
// Define FIFO_ALMOST_FLAGS_EN to add the almost_full / almost_empty outputs.
module fifo_ctrl #(
  parameter int DW = 32,
  parameter int AW = 3
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          wr_en,
  input  logic          rd_en,
  input  logic [DW-1:0] rd_data,
  output logic [AW-1:0] wr_addr,
  output logic          we,
  output logic [AW-1:0] rd_addr,
  output logic [DW-1:0] dout,
  output logic          full,
  output logic          empty,
  output logic [AW:0]   data_count,
`ifdef FIFO_ALMOST_FLAGS_EN
  output logic          almost_full,
  output logic          almost_empty,
`endif
  output logic          wr_ack,
  output logic          wr_err,
  output logic          rd_ack,
  output logic          rd_err
);

  localparam int DEPTH = 2 ** AW;
  localparam logic [AW:0] CountFull = (AW + 1)'(DEPTH);
  localparam logic [AW:0] CountZero = '0;

  localparam logic [2:0] StInit  = 3'd0;
  localparam logic [2:0] StNoOp  = 3'd1;
  localparam logic [2:0] StWrite = 3'd2;
  localparam logic [2:0] StWrErr = 3'd3;
  localparam logic [2:0] StRead  = 3'd4;
  localparam logic [2:0] StRdErr = 3'd5;

  logic [2:0]    state_q, state_d;
  logic [AW-1:0] head_q, tail_q;
  logic [AW:0]   count_q;
  logic [DW-1:0] dout_q;
  logic          wr_ok, rd_ok;

  assign full  = (count_q == CountFull);
  assign empty = (count_q == CountZero);

  // Simultaneous requests cancel each other and are treated as idle.
  assign wr_ok = wr_en & ~rd_en & ~full;
  assign rd_ok = rd_en & ~wr_en & ~empty;

  always_comb begin
    state_d = StNoOp;
    if (wr_en && !rd_en) begin
      state_d = full ? StWrErr : StWrite;
    end else if (rd_en && !wr_en) begin
      state_d = empty ? StRdErr : StRead;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= StInit;
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      dout_q  <= '0;
    end else begin
      state_q <= state_d;
      if (wr_ok) begin
        tail_q  <= tail_q + AW'(1);
        count_q <= count_q + (AW + 1)'(1);
      end else if (rd_ok) begin
        head_q  <= head_q + AW'(1);
        count_q <= count_q - (AW + 1)'(1);
        dout_q  <= rd_data;
      end
    end
  end

  assign we         = wr_ok;
  assign wr_addr    = tail_q;
  assign rd_addr    = head_q;
  assign dout       = dout_q;
  assign data_count = count_q;

  assign wr_ack = (state_q == StWrite);
  assign wr_err = (state_q == StWrErr);
  assign rd_ack = (state_q == StRead);
  assign rd_err = (state_q == StRdErr);

`ifdef FIFO_ALMOST_FLAGS_EN
  assign almost_full  = (count_q >= CountFull - (AW + 1)'(1));
  assign almost_empty = (count_q <= (AW + 1)'(1));
`endif

endmodule
